// File: rtl/levinson_k_seq_if.sv
// Handshake bundle for the sequential reflection-coefficient stage.
//   master : drives in_valid, q, e, out_ready; observes in_ready, out_valid, k, sat, div_by_zero
//   slave  : the divider side (levinson_k_seq)
//   in_valid/in_ready   : operand handshake (q signed, e unsigned)
//   out_valid/out_ready : result handshake (k signed, sat, div_by_zero)
interface levinson_k_seq_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] e;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] k;
   logic             sat;
   logic             div_by_zero;

   modport master (
      output in_valid, q, e, out_ready,
      input  in_ready, out_valid, k, sat, div_by_zero
   );

   modport slave (
      input  in_valid, q, e, out_ready,
      output in_ready, out_valid, k, sat, div_by_zero
   );
endinterface

// File: rtl/levinson_k_seq.sv
// Sequential Levinson-Durbin reflection coefficient k = -q/e in fixed point.
// Radix-2 restoring divider, one quotient bit per cycle, symmetric saturation.
//   clk, rst : clock, synchronous active-high reset
//   bus      : levinson_k_seq_if slave modport (operand and result handshakes)
// Latency from accept edge: 2 cycles on the e==0/overflow path, WIDTH+2 otherwise.
module levinson_k_seq #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned Q_FRAC = 33,
   parameter int unsigned E_FRAC = 34,
   parameter int unsigned K_FRAC = 31,
   parameter bit          ROUND  = 1'b0
) (
   input logic              clk,
   input logic              rst,
   levinson_k_seq_if.slave  bus
);
   localparam int          SHIFT = int'(K_FRAC) - int'(Q_FRAC) + int'(E_FRAC);
   localparam int unsigned W     = WIDTH;
   localparam int unsigned CW    = $clog2(WIDTH + 1);

   if (SHIFT < 0 || SHIFT > int'(WIDTH) || WIDTH < 2) begin : g_bad_params
      $error("levinson_k_seq: SHIFT must lie in [0, WIDTH] and WIDTH >= 2");
   end

   typedef enum logic [1:0] {StIdle, StCheck, StDiv, StDone} state_e;

   localparam logic [W-1:0] KMAX = {1'b0, {(W-1){1'b1}}};

   state_e          state_q, state_d;
   logic [W-1:0]    mag_q, mag_d;      // |q|, holds 2^(W-1) for the most negative q
   logic            neg_q, neg_d;      // q < 0
   logic [W-1:0]    den_q, den_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;      // low dividend bits shift out, quotient bits shift in
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    k_q, k_d;
   logic            sat_q, sat_d;
   logic            dbz_q, dbz_d;

   logic [2*W-1:0]  dividend;
   logic            ovf;
   logic [W:0]      trial, diff;
   logic            ge;
   logic [W-1:0]    rem_nx, quo_nx, res;
   logic            rnd;

   always_comb begin
      dividend = {{W{1'b0}}, mag_q} << SHIFT;
      // Quotient would not fit in W-1 magnitude bits.
      ovf      = dividend >= {1'b0, den_q, {(W-1){1'b0}}};
      trial    = {rem_q, quo_q[W-1]};
      diff     = trial - {1'b0, den_q};
      ge       = ~diff[W];
      rem_nx   = ge ? diff[W-1:0] : trial[W-1:0];
      quo_nx   = {quo_q[W-2:0], ge};
      rnd      = ROUND && ({rem_nx, 1'b0} >= {1'b0, den_q});
      // Quotient < 2^(W-1), so a round-up can at most reach 2^(W-1).
      res      = quo_nx + W'(rnd);
   end

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      neg_d   = neg_q;
      den_d   = den_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      sat_d   = sat_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               neg_d   = bus.q[W-1];
               mag_d   = bus.q[W-1] ? -bus.q : bus.q;
               den_d   = bus.e;
               state_d = StCheck;
            end
         end
         StCheck: begin
            cnt_d = '0;
            dbz_d = (den_q == '0);
            if (den_q == '0) begin
               sat_d   = (mag_q != '0);
               k_d     = (mag_q == '0) ? '0 : (neg_q ? KMAX : -KMAX);
               state_d = StDone;
            end else if (ovf) begin
               sat_d   = 1'b1;
               k_d     = neg_q ? KMAX : -KMAX;
               state_d = StDone;
            end else begin
               sat_d   = 1'b0;
               rem_d   = dividend[2*W-1:W];
               quo_d   = dividend[W-1:0];
               state_d = StDiv;
            end
         end
         StDiv: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               cnt_d   = '0;
               state_d = StDone;
               if (res[W-1]) begin
                  sat_d = 1'b1;
                  k_d   = neg_q ? KMAX : -KMAX;
               end else begin
                  k_d   = neg_q ? res : -res;
               end
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mag_q   <= '0;
         neg_q   <= 1'b0;
         den_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
         sat_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         neg_q   <= neg_d;
         den_q   <= den_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         sat_q   <= sat_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.in_ready    = (state_q == StIdle);
   assign bus.out_valid   = (state_q == StDone);
   assign bus.k           = k_q;
   assign bus.sat         = sat_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_levinson_k_seq.sv
// Self-checking bench for levinson_k_seq: a truncating and a rounding instance run
// in lockstep on the same operands, checked against an arbitrary-precision model.
module tb_levinson_k_seq;
   localparam int unsigned W      = 32;
   localparam int          SHIFT  = 32;
   localparam int          MAXLAT = W + 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] q_drv = '0;
   logic [W-1:0] e_drv = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   levinson_k_seq_if #(.WIDTH(W)) if0 ();
   levinson_k_seq_if #(.WIDTH(W)) if1 ();

   assign if0.in_valid  = in_valid;
   assign if0.q         = q_drv;
   assign if0.e         = e_drv;
   assign if0.out_ready = out_ready;
   assign if1.in_valid  = in_valid;
   assign if1.q         = q_drv;
   assign if1.e         = e_drv;
   assign if1.out_ready = out_ready;

   levinson_k_seq #(.WIDTH(W), .Q_FRAC(33), .E_FRAC(34), .K_FRAC(31), .ROUND(1'b0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   levinson_k_seq #(.WIDTH(W), .Q_FRAC(33), .E_FRAC(34), .K_FRAC(31), .ROUND(1'b1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // k = -sign(q) * R, R = trunc or round-half-up of |q|*2^SHIFT/e, clamped symmetric.
   function automatic void ref_model(input logic [W-1:0] qv, input logic [W-1:0] ev,
                                     input bit rnd, output logic [W-1:0] kv,
                                     output bit sv, output bit dv, output int lat);
      logic [127:0] mag, num, r, maxv;
      maxv = (128'd1 << (W - 1)) - 128'd1;
      mag  = qv[W-1] ? ((128'd1 << W) - {96'd0, qv}) : {96'd0, qv};
      num  = mag << SHIFT;
      dv   = (ev == '0);
      sv   = 1'b0;
      lat  = MAXLAT;
      r    = '0;
      if (ev == '0) begin
         lat = 2;
         sv  = (mag != '0);
         if (sv) r = maxv;
      end else begin
         r = num / {96'd0, ev};
         if (r > maxv) begin
            lat = 2;
            r   = maxv;
            sv  = 1'b1;
         end else if (rnd) begin
            r = (2 * num + {96'd0, ev}) / (2 * {96'd0, ev});
            if (r > maxv) begin
               r  = maxv;
               sv = 1'b1;
            end
         end
      end
      kv = qv[W-1] ? r[W-1:0] : -r[W-1:0];
   endfunction

   task automatic run_txn(input logic [W-1:0] qv, input logic [W-1:0] ev, input int bp,
                          input string tag);
      logic [W-1:0] k0, k1;
      bit           s0, s1, d0, d1;
      int           l0, l1, lat, guard;
      ref_model(qv, ev, 1'b0, k0, s0, d0, l0);
      ref_model(qv, ev, 1'b1, k1, s1, d1, l1);

      @(negedge clk);
      q_drv    = qv;
      e_drv    = ev;
      in_valid = 1'b1;
      guard    = 0;
      while (!if0.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_eq({tag, " in_ready"}, 64'(if0.in_ready), 64'd1);

      // Accepted on the next rising edge; operands are scrambled afterwards.
      @(negedge clk);
      in_valid = 1'b0;
      q_drv    = $urandom;
      e_drv    = $urandom;
      lat      = 1;
      while (!if0.out_valid && lat < MAXLAT + 5) begin
         @(negedge clk);
         lat++;
      end
      check_eq({tag, " latency"}, 64'(lat), 64'(l0));
      check_eq({tag, " out_valid1"}, 64'(if1.out_valid), 64'd1);
      check_eq({tag, " k trunc"}, 64'(if0.k), 64'(k0));
      check_eq({tag, " sat trunc"}, 64'(if0.sat), 64'(s0));
      check_eq({tag, " dbz trunc"}, 64'(if0.div_by_zero), 64'(d0));
      check_eq({tag, " k round"}, 64'(if1.k), 64'(k1));
      check_eq({tag, " sat round"}, 64'(if1.sat), 64'(s1));
      check_eq({tag, " dbz round"}, 64'(if1.div_by_zero), 64'(d1));
      check_eq({tag, " busy"}, 64'(if0.in_ready), 64'd0);

      // Offer another operand under backpressure; it must not be taken.
      in_valid = (bp > 0);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check_eq({tag, " bp k"}, 64'(if0.k), 64'(k0));
         check_eq({tag, " bp valid"}, 64'(if0.out_valid), 64'd1);
         check_eq({tag, " bp in_ready"}, 64'(if0.in_ready), 64'd0);
         check_eq({tag, " bp flags"}, 64'({if1.sat, if1.div_by_zero}), 64'({s1, d1}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, " released"}, 64'({if0.out_valid, if0.in_ready}), 64'b01);
   endtask

   initial begin
      logic [W-1:0] qr, er;
      int           bp;

      repeat (3) @(negedge clk);
      check_eq("reset in_ready", 64'(if0.in_ready), 64'd1);
      check_eq("reset out_valid", 64'(if0.out_valid), 64'd0);
      check_eq("reset k", 64'(if0.k), 64'd0);
      check_eq("reset flags", 64'({if0.sat, if0.div_by_zero}), 64'd0);
      rst = 1'b0;

      run_txn(32'h2000_0000, 32'h8000_0000, 0, "half");
      run_txn(32'hC000_0000, 32'h8000_0000, 0, "ovf");
      run_txn(32'h0000_0001, 32'h0000_0006, 10, "third");
      run_txn(32'h0000_0005, 32'h0000_0000, 0, "dbz q5");
      run_txn(32'h0000_0000, 32'h0000_0000, 0, "dbz q0");
      run_txn(32'h8000_0000, 32'hFFFF_FFFF, 2, "qmin");
      run_txn(32'h0000_0000, 32'h0000_1234, 0, "q0");
      run_txn(32'hFFFF_FFFF, 32'h0000_0003, 0, "neg round");

      // Abort in the divide phase: counter reaches 10 twelve falling edges after accept.
      @(negedge clk);
      q_drv    = 32'h0000_0001;
      e_drv    = 32'h0000_0006;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort out_valid", 64'(if0.out_valid), 64'd0);
      check_eq("abort in_ready", 64'(if0.in_ready), 64'd1);
      check_eq("abort k", 64'(if0.k), 64'd0);
      check_eq("abort k round", 64'(if1.k), 64'd0);
      run_txn(32'h0000_0001, 32'h0000_0006, 0, "after abort");

      for (int n = 0; n < 40; n++) begin
         qr = W'($urandom) >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) qr = -qr;
         if ($urandom_range(0, 15) == 0) qr = 32'h8000_0000;
         er = W'($urandom) >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) er = '0;
         bp = $urandom_range(0, 3);
         run_txn(qr, er, bp, $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
